// File: rtl/adma_as_atx_dispatch.sv
// AXI-transaction dispatch: forks an AR+AW bundle onto the master channels and tracks writes until B.
// Optional macro ADMA_DISP_BRESP_CHK_EN enables the sticky B-response error flag (tx_err).
module adma_as_atx_dispatch #(
  parameter int SRC_ADDR_W = 32,
  parameter int DST_ADDR_W = 32,
  parameter int MST_ID_W   = 5,
  parameter int ATX_LEN_W  = 8,
  parameter int MAX_OUTST  = 4,
  localparam int OUTST_W   = $clog2(MAX_OUTST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MST_ID_W-1:0]   atx_arid,
  input  logic [SRC_ADDR_W-1:0] atx_araddr,
  input  logic [ATX_LEN_W-1:0]  atx_arlen,
  input  logic [1:0]            atx_arburst,
  input  logic [MST_ID_W-1:0]   atx_awid,
  input  logic [DST_ADDR_W-1:0] atx_awaddr,
  input  logic [ATX_LEN_W-1:0]  atx_awlen,
  input  logic [1:0]            atx_awburst,
  input  logic                  atx_last,
  input  logic                  atx_vld,
  output logic                  atx_rdy,
  output logic [MST_ID_W-1:0]   m_arid,
  output logic [SRC_ADDR_W-1:0] m_araddr,
  output logic [ATX_LEN_W-1:0]  m_arlen,
  output logic [1:0]            m_arburst,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [MST_ID_W-1:0]   m_awid,
  output logic [DST_ADDR_W-1:0] m_awaddr,
  output logic [ATX_LEN_W-1:0]  m_awlen,
  output logic [1:0]            m_awburst,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [OUTST_W-1:0]    outst_cnt,
  output logic                  tx_done,
  output logic                  tx_err,
  input  logic                  err_clr
);

  localparam int PTR_W = $clog2(MAX_OUTST);

  logic                 accept_s;
  logic                 b_hs_s;
  logic [OUTST_W-1:0]   outst_cnt_r;
  logic [MAX_OUTST-1:0] last_fifo_r;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic                 tx_done_r;

  // Credit is the registered count, so a freed slot becomes visible one cycle after B.
  assign atx_rdy  = (~m_arvalid | m_arready) & (~m_awvalid | m_awready) &
                    (outst_cnt_r < OUTST_W'(MAX_OUTST));
  assign accept_s = atx_vld & atx_rdy;
  assign m_bready = (outst_cnt_r != {OUTST_W{1'b0}});
  assign b_hs_s   = m_bvalid & m_bready;
  assign outst_cnt = outst_cnt_r;
  assign tx_done   = tx_done_r;

  // AR channel: payload latched on accept, valid cleared on its own handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      m_arvalid <= 1'b0;
      m_arid    <= {MST_ID_W{1'b0}};
      m_araddr  <= {SRC_ADDR_W{1'b0}};
      m_arlen   <= {ATX_LEN_W{1'b0}};
      m_arburst <= 2'b00;
    end else if (accept_s) begin
      m_arvalid <= 1'b1;
      m_arid    <= atx_arid;
      m_araddr  <= atx_araddr;
      m_arlen   <= atx_arlen;
      m_arburst <= atx_arburst;
    end else if (m_arready) begin
      m_arvalid <= 1'b0;
    end else begin
      m_arvalid <= m_arvalid;
    end
  end

  // AW channel: independent of AR so a slow AW slave never stalls the AR beat
  always_ff @(posedge clk) begin
    if (rst) begin
      m_awvalid <= 1'b0;
      m_awid    <= {MST_ID_W{1'b0}};
      m_awaddr  <= {DST_ADDR_W{1'b0}};
      m_awlen   <= {ATX_LEN_W{1'b0}};
      m_awburst <= 2'b00;
    end else if (accept_s) begin
      m_awvalid <= 1'b1;
      m_awid    <= atx_awid;
      m_awaddr  <= atx_awaddr;
      m_awlen   <= atx_awlen;
      m_awburst <= atx_awburst;
    end else if (m_awready) begin
      m_awvalid <= 1'b0;
    end else begin
      m_awvalid <= m_awvalid;
    end
  end

  // Outstanding-write counter
  always_ff @(posedge clk) begin
    if (rst) begin
      outst_cnt_r <= {OUTST_W{1'b0}};
    end else begin
      case ({accept_s, b_hs_s})
        2'b10:   outst_cnt_r <= outst_cnt_r + OUTST_W'(1);
        2'b01:   outst_cnt_r <= outst_cnt_r - OUTST_W'(1);
        default: outst_cnt_r <= outst_cnt_r;
      endcase
    end
  end

  // Last-flag FIFO; depth equals the credit limit so it can never overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      last_fifo_r <= {MAX_OUTST{1'b0}};
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      tx_done_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        last_fifo_r[wr_ptr_r] <= atx_last;
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (b_hs_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      tx_done_r <= b_hs_s & last_fifo_r[rd_ptr_r];
    end
  end

`ifdef ADMA_DISP_BRESP_CHK_EN
  logic tx_err_r;
  logic unused_bresp;
  assign unused_bresp = m_bresp[0];
  assign tx_err       = tx_err_r;

  // Sticky error; a new SLVERR/DECERR takes priority over a clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_err_r <= 1'b0;
    end else if (b_hs_s & m_bresp[1]) begin
      tx_err_r <= 1'b1;
    end else if (err_clr) begin
      tx_err_r <= 1'b0;
    end else begin
      tx_err_r <= tx_err_r;
    end
  end
`else
  logic unused_err_in;
  assign unused_err_in = ^{m_bresp, err_clr};
  assign tx_err        = 1'b0;
`endif

endmodule

// File: tb/tb_adma_as_atx_dispatch.sv
// Directed self-checking bench for adma_as_atx_dispatch (expected tx_err follows ADMA_DISP_BRESP_CHK_EN).
module tb_adma_as_atx_dispatch;

  localparam int SRC_ADDR_W = 32;
  localparam int DST_ADDR_W = 32;
  localparam int MST_ID_W   = 5;
  localparam int ATX_LEN_W  = 8;
  localparam int MAX_OUTST  = 4;
  localparam int OUTST_W    = $clog2(MAX_OUTST + 1);

`ifdef ADMA_DISP_BRESP_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic                  clk;
  logic                  rst;
  logic [MST_ID_W-1:0]   atx_arid, atx_awid, m_arid, m_awid;
  logic [SRC_ADDR_W-1:0] atx_araddr, m_araddr;
  logic [DST_ADDR_W-1:0] atx_awaddr, m_awaddr;
  logic [ATX_LEN_W-1:0]  atx_arlen, atx_awlen, m_arlen, m_awlen;
  logic [1:0]            atx_arburst, atx_awburst, m_arburst, m_awburst;
  logic                  atx_last, atx_vld, atx_rdy;
  logic                  m_arvalid, m_arready, m_awvalid, m_awready;
  logic [1:0]            m_bresp;
  logic                  m_bvalid, m_bready;
  logic [OUTST_W-1:0]    outst_cnt;
  logic                  tx_done, tx_err, err_clr;

  adma_as_atx_dispatch #(
    .SRC_ADDR_W(SRC_ADDR_W), .DST_ADDR_W(DST_ADDR_W), .MST_ID_W(MST_ID_W),
    .ATX_LEN_W(ATX_LEN_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk), .rst(rst),
    .atx_arid(atx_arid), .atx_araddr(atx_araddr), .atx_arlen(atx_arlen), .atx_arburst(atx_arburst),
    .atx_awid(atx_awid), .atx_awaddr(atx_awaddr), .atx_awlen(atx_awlen), .atx_awburst(atx_awburst),
    .atx_last(atx_last), .atx_vld(atx_vld), .atx_rdy(atx_rdy),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .outst_cnt(outst_cnt), .tx_done(tx_done), .tx_err(tx_err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; atx_vld = 1'b0; atx_last = 1'b0;
    atx_arid = 5'd3; atx_araddr = 32'h0000_1000; atx_arlen = 8'd15; atx_arburst = 2'b01;
    atx_awid = 5'd3; atx_awaddr = 32'h8000_2000; atx_awlen = 8'd15; atx_awburst = 2'b01;
    m_arready = 1'b0; m_awready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00; err_clr = 1'b0;
    tick; tick;
    rst = 1'b0;
    #1;
    check("rst_arvalid", 64'(m_arvalid), 64'd0);
    check("rst_awvalid", 64'(m_awvalid), 64'd0);
    check("rst_outst",   64'(outst_cnt), 64'd0);
    check("rst_rdy",     64'(atx_rdy),   64'd1);
    check("rst_bready",  64'(m_bready),  64'd0);
    check("rst_done",    64'(tx_done),   64'd0);
    check("rst_err",     64'(tx_err),    64'd0);
    check("rst_araddr",  64'(m_araddr),  64'd0);

    // Single atx, AW slave three cycles late
    atx_last = 1'b1; atx_vld = 1'b1; m_arready = 1'b1; m_awready = 1'b0;
    #1;
    check("t1_rdy_idle", 64'(atx_rdy), 64'd1);
    tick;
    atx_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) m_awready = 1'b1;
      #1;
      check("t1_awvalid", 64'(m_awvalid), 64'd1);
      check("t1_awaddr",  64'(m_awaddr),  64'h8000_2000);
      check("t1_awlen",   64'(m_awlen),   64'd15);
      check("t1_arvalid", 64'(m_arvalid), 64'(i == 0));
      check("t1_rdy",     64'(atx_rdy),   64'(i == 3));
      check("t1_outst",   64'(outst_cnt), 64'd1);
      if (i == 0) begin
        check("t1_araddr", 64'(m_araddr), 64'h1000);
        check("t1_arlen",  64'(m_arlen),  64'd15);
      end
      tick;
    end
    m_bvalid = 1'b1; m_bresp = 2'b00;
    #1;
    check("t2_awvalid_clr", 64'(m_awvalid), 64'd0);
    check("t2_bready",      64'(m_bready),  64'd1);
    tick;
    m_bvalid = 1'b0;
    #1;
    check("t2_outst0", 64'(outst_cnt), 64'd0);
    check("t2_done",   64'(tx_done),   64'd1);
    tick;
    check("t2_done_pulse", 64'(tx_done), 64'd0);

    // Four back-to-back accepts fill the credit
    for (int i = 0; i < 4; i++) begin
      atx_araddr = 32'h0000_2000 + 32'(i) * 32'h100;
      atx_last   = (i == 3);
      atx_vld    = 1'b1;
      #1;
      check("t3_rdy_fill", 64'(atx_rdy), 64'd1);
      tick;
    end
    #1;
    check("t3_outst4",   64'(outst_cnt), 64'd4);
    check("t3_rdy_full", 64'(atx_rdy),   64'd0);
    check("t3_araddr",   64'(m_araddr),  64'h2300);
    m_bvalid = 1'b1;
    #1;
    check("t3_rdy_b_cycle", 64'(atx_rdy), 64'd0);
    tick;
    m_bvalid = 1'b0;
    #1;
    check("t3_outst3",  64'(outst_cnt), 64'd3);
    check("t3_rdy_free", 64'(atx_rdy),  64'd1);
    check("t3_done0",   64'(tx_done),   64'd0);
    atx_vld  = 1'b0;
    m_bvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("t3_drain_done",  64'(tx_done),   64'(i == 2));
      check("t3_drain_outst", 64'(outst_cnt), 64'(2 - i));
    end
    tick;
    check("t3_no_underflow", 64'(outst_cnt), 64'd0);
    m_bvalid = 1'b0;

    // Simultaneous accept and B at outst_cnt=2; flags pushed 0,1 then 0
    atx_vld = 1'b1; atx_last = 1'b0;
    tick;
    atx_last = 1'b1;
    tick;
    atx_last = 1'b0; m_bvalid = 1'b1;
    #1;
    check("t4_outst2",  64'(outst_cnt), 64'd2);
    check("t4_rdy",     64'(atx_rdy),   64'd1);
    tick;
    atx_vld = 1'b0;
    check("t4_outst_hold", 64'(outst_cnt), 64'd2);
    check("t4_done_a",     64'(tx_done),   64'd0);
    tick;
    check("t4_done_b",  64'(tx_done),   64'd1);
    check("t4_outst1",  64'(outst_cnt), 64'd1);
    tick;
    m_bvalid = 1'b0;
    check("t4_done_c",  64'(tx_done),   64'd0);
    check("t4_outst0",  64'(outst_cnt), 64'd0);

    // Last sequence 0,0,1 with three B responses
    for (int i = 0; i < 3; i++) begin
      atx_vld = 1'b1; atx_last = (i == 2);
      tick;
    end
    atx_vld = 1'b0; m_bvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("t5_done", 64'(tx_done), 64'(i == 2));
    end
    m_bvalid = 1'b0;

    // Error response handling
    atx_vld = 1'b1; atx_last = 1'b0;
    tick;
    atx_vld = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b10;
    tick;
    m_bvalid = 1'b0; m_bresp = 2'b00;
    check("t6_err_set", 64'(tx_err), 64'(EXP_ERR));
    tick;
    check("t6_err_sticky", 64'(tx_err), 64'(EXP_ERR));
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    check("t6_err_clr", 64'(tx_err), 64'd0);
    atx_vld = 1'b1;
    tick;
    atx_vld = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b11; err_clr = 1'b1;
    tick;
    m_bvalid = 1'b0; m_bresp = 2'b00; err_clr = 1'b0;
    check("t6_err_wins", 64'(tx_err), 64'(EXP_ERR));
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    check("t6_err_clr2", 64'(tx_err), 64'd0);

    // Reset mid-operation with AW pending and three writes outstanding
    for (int i = 0; i < 3; i++) begin
      atx_vld = 1'b1;
      tick;
    end
    atx_vld = 1'b0; m_awready = 1'b0;
    #1;
    check("t7_outst3",  64'(outst_cnt), 64'd3);
    check("t7_awvalid", 64'(m_awvalid), 64'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    check("t7_arvalid", 64'(m_arvalid), 64'd0);
    check("t7_awvalid0", 64'(m_awvalid), 64'd0);
    check("t7_outst0",  64'(outst_cnt), 64'd0);
    check("t7_rdy",     64'(atx_rdy),   64'd1);
    check("t7_bready",  64'(m_bready),  64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
